// File: rtl/mem_dump_uart_pkg.sv
// Shared types and constants for the memory-dump UART transmitter.
package mem_dump_uart_pkg;

  localparam int unsigned FRAME_BITS    = 10;
  localparam int unsigned DEF_CLK_DIV   = 104;
  localparam int unsigned DEF_READ_WAIT = 2;
  localparam int unsigned DEF_ADR_WIDTH = 21;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAITCTS = 3'd2,
    ST_SEND    = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Two's complement of the running sum, so data bytes plus checksum sum to zero.
  function automatic logic [7:0] csum_byte(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/mem_dump_uart_if.sv
// External memory read bus: address and strobe out, data back.
interface mem_dump_uart_if #(
  parameter int unsigned ADR_WIDTH = 21
);
  logic [ADR_WIDTH-1:0] adr;
  logic                 read;
  logic [7:0]           din;

  modport master (output adr, output read, input din);
  modport slave  (input adr, input read, output din);
endinterface

// File: rtl/mem_dump_uart_tx_8n1.sv
// UART 8N1 transmitter: bit-rate divider plus 10-bit shift register, idle high.
module uart_tx_8n1
  import mem_dump_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bits_q, bits_d;
  logic                  ready_q, ready_d;

  // Shifting in ones keeps the line high once the stop bit has gone out.
  always_comb begin
    shift_d = shift_q;
    div_d   = div_q;
    bits_d  = bits_q;
    ready_d = ready_q;
    if (load && ready_q) begin
      shift_d = {1'b1, data, 1'b0};
      bits_d  = BIT_W'(FRAME_BITS);
      div_d   = DIV_W'(CLK_DIV - 1);
      ready_d = 1'b0;
    end else if (bits_q != '0) begin
      if (div_q == '0) begin
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
        bits_d  = bits_q - BIT_W'(1);
        div_d   = DIV_W'(CLK_DIV - 1);
        if (bits_q == BIT_W'(1)) ready_d = 1'b1;
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_q <= '1;
      div_q   <= '0;
      bits_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      shift_q <= shift_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      ready_q <= ready_d;
    end
  end

  assign tx    = shift_q[0];
  assign ready = ready_q;

endmodule

// File: rtl/mem_dump_uart.sv
// Reads a memory range and streams it over UART 8N1, followed by a zero-sum checksum byte.
module mem_dump_uart
  import mem_dump_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned READ_WAIT = DEF_READ_WAIT,
  parameter int unsigned ADR_WIDTH = DEF_ADR_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [ADR_WIDTH-1:0] start_adr,
  input  logic [ADR_WIDTH-1:0] len,
  output logic                 tx,
  input  logic                 cts_n,
  output logic                 busy,
  output logic                 done,
  mem_dump_uart_if.master      mem
);

  localparam int unsigned WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

  state_e               state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [ADR_WIDTH-1:0] remain_q, remain_d;
  logic [7:0]           sum_q, sum_d;
  logic [7:0]           byte_q, byte_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 csum_q, csum_d;
  logic                 read_q, read_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cts_meta_q, cts_sync_q;
  logic                 cts_ok_c;
  logic                 tx_load_c;
  logic                 tx_ready;

  assign cts_ok_c = ~cts_sync_q;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    remain_d  = remain_q;
    sum_d     = sum_q;
    byte_d    = byte_q;
    wait_d    = wait_q;
    csum_d    = csum_q;
    read_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          adr_d    = start_adr;
          remain_d = len;
          sum_d    = '0;
          csum_d   = 1'b0;
          busy_d   = 1'b1;
          wait_d   = '0;
          if (len == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_READ;
            read_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (wait_q == WAIT_W'(READ_WAIT)) begin
          byte_d  = mem.din;
          sum_d   = sum_q + mem.din;
          state_d = ST_WAITCTS;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          read_d = 1'b1;
        end
      end
      ST_WAITCTS: begin
        if (cts_ok_c && tx_ready) begin
          tx_load_c = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // tx_ready rises in the cycle right after the stop bit completes.
        if (tx_ready) begin
          if (csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            remain_d = remain_q - ADR_WIDTH'(1);
            adr_d    = adr_q + ADR_WIDTH'(1);
            if (remain_q != ADR_WIDTH'(1)) begin
              state_d = ST_READ;
              read_d  = 1'b1;
              wait_d  = '0;
            end else begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        byte_d  = csum_byte(sum_q);
        csum_d  = 1'b1;
        state_d = ST_WAITCTS;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      remain_q   <= '0;
      sum_q      <= '0;
      byte_q     <= '0;
      wait_q     <= '0;
      csum_q     <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      remain_q   <= remain_d;
      sum_q      <= sum_d;
      byte_q     <= byte_d;
      wait_q     <= wait_d;
      csum_q     <= csum_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  uart_tx_8n1 #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk    (clk),
    .n_reset(n_reset),
    .load   (tx_load_c),
    .data   (byte_q),
    .tx     (tx),
    .ready  (tx_ready)
  );

  assign mem.adr  = adr_q;
  assign mem.read = read_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
